uart_cmd_bridge: RTL and testbench

- UART-to-bus command bridge: serial receiver, command parser, bus master and serial transmitter in one block.
- Host sends a command byte, then a little-endian address, then (for writes) little-endian data.
- Block issues one bus transaction per command and returns an ack, the read data, or an error byte on tx.
- Successor to the fixed 32-bit loader path: address width, data width and baud rate are parametrised, and it adds responses and error handling.

---
 rtl/uart_cmd_bridge.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_uart_cmd_bridge.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_bridge.sv
// rtl/uart_cmd_bridge.sv - UART command bridge: rx deframer, command parser, bus master, tx framer
// Optional inter-byte timeout on the address/data phase: define UART_CMD_TIMEOUT_EN.
module uart_cmd_bridge #(
  parameter int         CLKS_PER_BIT = 5208,
  parameter int         ADDR_BYTES   = 4,
  parameter int         DATA_BYTES   = 4,
  parameter logic [7:0] CMD_WRITE    = 8'h56,
  parameter logic [7:0] CMD_READ     = 8'h55,
  parameter int         TIMEOUT_CLKS = 20 * CLKS_PER_BIT * 10
) (
  input  logic                    clk,
  input  logic                    reset_L,
  input  logic                    rx,
  output logic                    tx,
  output logic                    bus_req,
  output logic                    bus_we,
  output logic [8*ADDR_BYTES-1:0] bus_addr,
  output logic [8*DATA_BYTES-1:0] bus_wdata,
  input  logic                    bus_ack,
  input  logic [8*DATA_BYTES-1:0] bus_rdata,
  output logic                    frame_err,
  output logic                    busy
);
  localparam int AW = 8 * ADDR_BYTES;
  localparam int DW = 8 * DATA_BYTES;
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [2:0] {P_IDLE, P_ADDR, P_DATA, P_BUS, P_RESP} p_state_t;
  typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_t;

  rx_state_t     rx_state, rx_state_n;
  logic          rx_meta, rx_sync, rx_prev;
  logic [CW-1:0] rx_cnt, rx_cnt_n;
  logic [2:0]    rx_bit, rx_bit_n;
  logic [7:0]    rx_shift, rx_shift_n;
  logic          rx_strobe, rx_strobe_n, frame_err_n;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      rx_meta   <= 1'b1;
      rx_sync   <= 1'b1;
      rx_prev   <= 1'b1;
      rx_state  <= R_IDLE;
      rx_cnt    <= '0;
      rx_bit    <= '0;
      rx_shift  <= '0;
      rx_strobe <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_meta   <= rx;
      rx_sync   <= rx_meta;
      rx_prev   <= rx_sync;
      rx_state  <= rx_state_n;
      rx_cnt    <= rx_cnt_n;
      rx_bit    <= rx_bit_n;
      rx_shift  <= rx_shift_n;
      rx_strobe <= rx_strobe_n;
      frame_err <= frame_err_n;
    end
  end

  // Start bit is re-sampled at half a bit so short glitches fall back to idle.
  always_comb begin
    rx_state_n  = rx_state;
    rx_cnt_n    = rx_cnt + 1'b1;
    rx_bit_n    = rx_bit;
    rx_shift_n  = rx_shift;
    rx_strobe_n = 1'b0;
    frame_err_n = 1'b0;
    case (rx_state)
      R_IDLE: begin
        rx_cnt_n = '0;
        if (rx_prev && !rx_sync) rx_state_n = R_START;
      end
      R_START: if (rx_cnt == HALF_END) begin
        rx_cnt_n   = '0;
        rx_bit_n   = '0;
        rx_state_n = rx_sync ? R_IDLE : R_DATA;
      end
      R_DATA: if (rx_cnt == BIT_END) begin
        rx_cnt_n   = '0;
        rx_shift_n = {rx_sync, rx_shift[7:1]};
        rx_bit_n   = rx_bit + 3'd1;
        if (rx_bit == 3'd7) rx_state_n = R_STOP;
      end
      R_STOP: if (rx_cnt == BIT_END) begin
        rx_cnt_n   = '0;
        rx_state_n = R_IDLE;
        if (rx_sync) rx_strobe_n = 1'b1;
        else         frame_err_n = 1'b1;
      end
      default: rx_state_n = R_IDLE;
    endcase
  end

  p_state_t        p_state, p_state_n;
  logic [2:0]      idx, idx_n;
  logic [AW-1:0]   addr_n;
  logic [DW-1:0]   wdata_n;
  logic            we_n, busy_n;
  logic            tx_load, tx_done;
  logic [DW-1:0]   tx_load_data;
  logic [2:0]      tx_load_cnt;
  logic            to_expired;

`ifdef UART_CMD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TW-1:0] TO_END = TW'(TIMEOUT_CLKS);
  logic [TW-1:0] to_cnt;
  logic          in_frame;

  assign in_frame   = (p_state == P_ADDR) || (p_state == P_DATA);
  assign to_expired = in_frame && !rx_strobe && (to_cnt == TO_END);

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L)                              to_cnt <= '0;
    else if (in_frame && !rx_strobe && !to_expired) to_cnt <= to_cnt + 1'b1;
    else                                       to_cnt <= '0;
  end
`else
  assign to_expired = 1'b0;
`endif

  assign bus_req = (p_state == P_BUS);

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      p_state   <= P_IDLE;
      idx       <= '0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_we    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      p_state   <= p_state_n;
      idx       <= idx_n;
      bus_addr  <= addr_n;
      bus_wdata <= wdata_n;
      bus_we    <= we_n;
      busy      <= busy_n;
    end
  end

  always_comb begin
    p_state_n    = p_state;
    idx_n        = idx;
    addr_n       = bus_addr;
    wdata_n      = bus_wdata;
    we_n         = bus_we;
    busy_n       = busy;
    tx_load      = 1'b0;
    tx_load_data = '0;
    tx_load_cnt  = 3'd1;
    case (p_state)
      P_IDLE: if (rx_strobe) begin
        idx_n = '0;
        if (rx_shift == CMD_WRITE || rx_shift == CMD_READ) begin
          we_n      = (rx_shift == CMD_WRITE);
          busy_n    = 1'b1;
          p_state_n = P_ADDR;
        end else begin
          tx_load      = 1'b1;
          tx_load_data = DW'(8'h3F);
          p_state_n    = P_RESP;
        end
      end
      P_ADDR: if (rx_strobe) begin
        for (int k = 0; k < ADDR_BYTES; k++)
          if (idx == 3'(k)) addr_n[8*k +: 8] = rx_shift;
        idx_n = idx + 3'd1;
        if (idx == 3'(ADDR_BYTES - 1)) begin
          idx_n     = '0;
          p_state_n = bus_we ? P_DATA : P_BUS;
        end
      end
      P_DATA: if (rx_strobe) begin
        for (int k = 0; k < DATA_BYTES; k++)
          if (idx == 3'(k)) wdata_n[8*k +: 8] = rx_shift;
        idx_n = idx + 3'd1;
        if (idx == 3'(DATA_BYTES - 1)) begin
          idx_n     = '0;
          p_state_n = P_BUS;
        end
      end
      P_BUS: if (bus_ack) begin
        p_state_n = P_RESP;
        tx_load   = 1'b1;
        if (bus_we) begin
          tx_load_data = DW'(8'h06);
        end else begin
          tx_load_data = bus_rdata;
          tx_load_cnt  = 3'(DATA_BYTES);
        end
      end
      P_RESP: if (tx_done) begin
        p_state_n = P_IDLE;
        busy_n    = 1'b0;
      end
      default: p_state_n = P_IDLE;
    endcase
    if (to_expired) begin
      p_state_n    = P_IDLE;
      idx_n        = '0;
      busy_n       = 1'b0;
      tx_load      = 1'b1;
      tx_load_data = DW'(8'h15);
      tx_load_cnt  = 3'd1;
    end
  end

  tx_state_t     tx_state, tx_state_n;
  logic [CW-1:0] tx_cnt, tx_cnt_n;
  logic [2:0]    tx_bit, tx_bit_n, tx_left, tx_left_n;
  logic [DW-1:0] tx_buf, tx_buf_n;
  logic [7:0]    tx_byte_n;
  logic          tx_n;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      tx_state <= T_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_left  <= '0;
      tx_buf   <= '0;
      tx       <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_bit   <= tx_bit_n;
      tx_left  <= tx_left_n;
      tx_buf   <= tx_buf_n;
      tx       <= tx_n;
    end
  end

  // Multi-byte responses chain stop -> start directly so there is no idle gap.
  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt + 1'b1;
    tx_bit_n   = tx_bit;
    tx_left_n  = tx_left;
    tx_buf_n   = tx_buf;
    tx_done    = 1'b0;
    case (tx_state)
      T_IDLE: begin
        tx_cnt_n = '0;
        if (tx_load) begin
          tx_buf_n   = tx_load_data;
          tx_left_n  = tx_load_cnt;
          tx_state_n = T_START;
        end
      end
      T_START: if (tx_cnt == BIT_END) begin
        tx_cnt_n   = '0;
        tx_bit_n   = '0;
        tx_state_n = T_DATA;
      end
      T_DATA: if (tx_cnt == BIT_END) begin
        tx_cnt_n = '0;
        tx_bit_n = tx_bit + 3'd1;
        if (tx_bit == 3'd7) tx_state_n = T_STOP;
      end
      T_STOP: if (tx_cnt == BIT_END) begin
        tx_cnt_n = '0;
        if (tx_left > 3'd1) begin
          tx_left_n  = tx_left - 3'd1;
          tx_buf_n   = tx_buf >> 8;
          tx_state_n = T_START;
        end else begin
          tx_state_n = T_IDLE;
          tx_done    = 1'b1;
        end
      end
      default: tx_state_n = T_IDLE;
    endcase
    tx_byte_n = tx_buf_n[7:0];
    tx_n      = 1'b1;
    if (tx_state_n == T_START)     tx_n = 1'b0;
    else if (tx_state_n == T_DATA) tx_n = tx_byte_n[tx_bit_n];
  end

endmodule

// File: tb/tb_uart_cmd_bridge.sv
// tb/tb_uart_cmd_bridge.sv - randomized self-checking bench for uart_cmd_bridge
// Drives a 4/4-byte instance and a 2/1-byte instance; timeout steps run when UART_CMD_TIMEOUT_EN is defined.
module tb_uart_cmd_bridge;
  localparam int CPB = 16;
  localparam int TO  = 20 * CPB * 10;

  logic        clk = 1'b0;
  logic        reset_L;
  logic        rx_a, tx_a, bus_req_a, bus_we_a, bus_ack_a, frame_err_a, busy_a;
  logic [31:0] bus_addr_a, bus_wdata_a, bus_rdata_a;
  logic        rx_b, tx_b, bus_req_b, bus_we_b, bus_ack_b, frame_err_b, busy_b;
  logic [15:0] bus_addr_b;
  logic [7:0]  bus_wdata_b, bus_rdata_b;

  int compared = 0;
  int mismatched = 0;
  int fe_a = 0;
  int ack_dly_a = 5, ack_dly_b = 5;
  logic [31:0] rdata_a = '0, rdata_b = '0;

  logic [7:0]  rq_a[$], rq_b[$];
  logic        q_we_a[$], q_we_b[$];
  logic [31:0] q_addr_a[$], q_addr_b[$], q_wd_a[$], q_wd_b[$];

  always #5 clk = ~clk;

  uart_cmd_bridge #(.CLKS_PER_BIT(CPB), .ADDR_BYTES(4), .DATA_BYTES(4)) dut_a (
    .clk(clk), .reset_L(reset_L), .rx(rx_a), .tx(tx_a),
    .bus_req(bus_req_a), .bus_we(bus_we_a), .bus_addr(bus_addr_a), .bus_wdata(bus_wdata_a),
    .bus_ack(bus_ack_a), .bus_rdata(bus_rdata_a), .frame_err(frame_err_a), .busy(busy_a));

  uart_cmd_bridge #(.CLKS_PER_BIT(CPB), .ADDR_BYTES(2), .DATA_BYTES(1)) dut_b (
    .clk(clk), .reset_L(reset_L), .rx(rx_b), .tx(tx_b),
    .bus_req(bus_req_b), .bus_we(bus_we_b), .bus_addr(bus_addr_b), .bus_wdata(bus_wdata_b),
    .bus_ack(bus_ack_b), .bus_rdata(bus_rdata_b), .frame_err(frame_err_b), .busy(busy_b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) if (frame_err_a === 1'b1) fe_a <= fe_a + 1;

  // Serial decoders for the two tx lines, sampling mid-bit on the falling clock edge.
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge tx_a);
      repeat (CPB / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin repeat (CPB) @(negedge clk); b[i] = tx_a; end
      repeat (CPB) @(negedge clk);
      chk("tx_stop_a", 32'(tx_a), 32'd1);
      rq_a.push_back(b);
    end
  end

  initial begin
    logic [7:0] b;
    forever begin
      @(negedge tx_b);
      repeat (CPB / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin repeat (CPB) @(negedge clk); b[i] = tx_b; end
      repeat (CPB) @(negedge clk);
      chk("tx_stop_b", 32'(tx_b), 32'd1);
      rq_b.push_back(b);
    end
  end

  // Bus slaves: log each request, check it holds until ack, ack after a set delay.
  initial begin
    logic changed;
    bus_ack_a = 1'b0; bus_rdata_a = '0;
    forever begin
      @(negedge clk);
      if (bus_req_a === 1'b1) begin
        q_we_a.push_back(bus_we_a); q_addr_a.push_back(bus_addr_a); q_wd_a.push_back(bus_wdata_a);
        changed = 1'b0;
        for (int i = 0; i < ack_dly_a && bus_req_a === 1'b1; i++) begin
          @(negedge clk);
          if (bus_req_a === 1'b1)
            changed = changed | (bus_we_a !== q_we_a[$]) | (bus_addr_a !== q_addr_a[$]) | (bus_wdata_a !== q_wd_a[$]);
        end
        if (bus_req_a === 1'b1) begin
          chk("req_hold_a", 32'(changed), 32'd0);
          bus_rdata_a = rdata_a; bus_ack_a = 1'b1;
          @(negedge clk);
          bus_ack_a = 1'b0; bus_rdata_a = '0;
          chk("req_drop_a", 32'(bus_req_a), 32'd0);
        end
      end
    end
  end

  initial begin
    logic changed;
    bus_ack_b = 1'b0; bus_rdata_b = '0;
    forever begin
      @(negedge clk);
      if (bus_req_b === 1'b1) begin
        q_we_b.push_back(bus_we_b); q_addr_b.push_back(32'(bus_addr_b)); q_wd_b.push_back(32'(bus_wdata_b));
        changed = 1'b0;
        for (int i = 0; i < ack_dly_b && bus_req_b === 1'b1; i++) begin
          @(negedge clk);
          if (bus_req_b === 1'b1)
            changed = changed | (bus_we_b !== q_we_b[$]) | (32'(bus_addr_b) !== q_addr_b[$]) | (32'(bus_wdata_b) !== q_wd_b[$]);
        end
        if (bus_req_b === 1'b1) begin
          chk("req_hold_b", 32'(changed), 32'd0);
          bus_rdata_b = rdata_b[7:0]; bus_ack_b = 1'b1;
          @(negedge clk);
          bus_ack_b = 1'b0; bus_rdata_b = '0;
          chk("req_drop_b", 32'(bus_req_b), 32'd0);
        end
      end
    end
  end

  function automatic int rq_size(input int sel);
    return (sel == 0) ? rq_a.size() : rq_b.size();
  endfunction

  function automatic logic [7:0] rq_at(input int sel, input int k);
    return (sel == 0) ? rq_a[k] : rq_b[k];
  endfunction

  function automatic int txn_size(input int sel);
    return (sel == 0) ? q_we_a.size() : q_we_b.size();
  endfunction

  task automatic send_byte(input int sel, input logic [7:0] b, input logic stopv);
    logic [9:0] fr;
    fr = {stopv, b, 1'b0};
    @(posedge clk);
    for (int i = 0; i < 10; i++) begin
      #1;
      if (sel == 0) rx_a = fr[i]; else rx_b = fr[i];
      repeat (CPB) @(posedge clk);
    end
    #1;
    if (sel == 0) rx_a = 1'b1; else rx_b = 1'b1;
    if (!stopv) repeat (CPB) @(posedge clk);
  endtask

  task automatic wait_bytes(input int sel, input int n, input int lim, input string tag);
    int c;
    c = 0;
    while (rq_size(sel) < n && c < lim) begin @(posedge clk); c++; end
    chk(tag, 32'(rq_size(sel)), 32'(n));
  endtask

  // Reference model: command bytes and expected bus transaction / response built from the protocol rules.
  task automatic run_cmd(input int sel, input bit wr, input logic [31:0] addr, input logic [31:0] data,
                         input int dly, input int bad_at, input bit tail);
    int ab, db, n0, fe0;
    logic [63:0] amod, dmod;
    logic [7:0] bytes[$];
    logic [7:0] exp_tx[$];
    ab = (sel == 0) ? 4 : 2;
    db = (sel == 0) ? 4 : 1;
    amod = 64'(addr) % (64'd1 << (8 * ab));
    dmod = 64'(data) % (64'd1 << (8 * db));
    bytes.push_back(wr ? 8'h56 : 8'h55);
    for (int k = 0; k < ab; k++) bytes.push_back(8'((amod >> (8 * k)) & 64'hFF));
    if (wr) begin
      for (int k = 0; k < db; k++) bytes.push_back(8'((dmod >> (8 * k)) & 64'hFF));
      exp_tx.push_back(8'h06);
    end else begin
      for (int k = 0; k < db; k++) exp_tx.push_back(8'((dmod >> (8 * k)) & 64'hFF));
    end
    if (sel == 0) begin ack_dly_a = dly; rdata_a = data; rq_a.delete(); end
    else          begin ack_dly_b = dly; rdata_b = data; rq_b.delete(); end
    n0 = txn_size(sel);
    fe0 = fe_a;
    for (int i = 0; i < bytes.size(); i++) begin
      send_byte(sel, bytes[i], 1'b1);
      if (i == 0) chk("busy_set", 32'((sel == 0) ? busy_a : busy_b), 32'd1);
      if (i == bad_at) send_byte(sel, 8'h77, 1'b0);
    end
    if (tail) send_byte(sel, 8'hA5, 1'b1);
    wait_bytes(sel, exp_tx.size(), 3000, "resp_count");
    chk("txn_count", 32'(txn_size(sel)), 32'(n0 + 1));
    if (txn_size(sel) > n0) begin
      chk("txn_we", 32'((sel == 0) ? q_we_a[n0] : q_we_b[n0]), 32'(wr));
      chk("txn_addr", (sel == 0) ? q_addr_a[n0] : q_addr_b[n0], 32'(amod));
      if (wr) chk("txn_wdata", (sel == 0) ? q_wd_a[n0] : q_wd_b[n0], 32'(dmod));
    end
    for (int k = 0; k < exp_tx.size() && k < rq_size(sel); k++)
      chk("resp_byte", 32'(rq_at(sel, k)), 32'(exp_tx[k]));
    if (sel == 0) chk("frame_err_count", 32'(fe_a), 32'(fe0 + ((bad_at >= 0) ? 1 : 0)));
    repeat (CPB + 4) @(posedge clk);
    #1;
    chk("busy_clear", 32'((sel == 0) ? busy_a : busy_b), 32'd0);
    chk("no_extra_resp", 32'(rq_size(sel)), 32'(exp_tx.size()));
  endtask

  initial begin
    int n0, fe0, c;
    rx_a = 1'b1; rx_b = 1'b1; reset_L = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_tx", 32'(tx_a), 32'd1);
    chk("rst_bus_req", 32'(bus_req_a), 32'd0);
    chk("rst_bus_we", 32'(bus_we_a), 32'd0);
    chk("rst_bus_addr", bus_addr_a, 32'd0);
    chk("rst_bus_wdata", bus_wdata_a, 32'd0);
    chk("rst_frame_err", 32'(frame_err_a), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_tx_b", 32'(tx_b), 32'd1);
    reset_L = 1'b1;
    repeat (20) @(posedge clk);

    run_cmd(0, 1'b1, 32'h0000_0001, 32'h00FF_00FF, 5, -1, 1'b0);
    run_cmd(0, 1'b0, 32'h0000_0001, 32'h00FF_00FF, 3, -1, 1'b0);

    rq_a.delete(); n0 = txn_size(0);
    send_byte(0, 8'hA5, 1'b1);
    wait_bytes(0, 1, 1000, "bad_cmd_count");
    if (rq_a.size() > 0) chk("bad_cmd_resp", 32'(rq_a[0]), 32'h3F);
    repeat (CPB + 4) @(posedge clk);
    chk("bad_cmd_no_req", 32'(txn_size(0)), 32'(n0));
    chk("bad_cmd_busy", 32'(busy_a), 32'd0);

    rq_a.delete(); n0 = txn_size(0); fe0 = fe_a;
    @(posedge clk); #1 rx_a = 1'b0;
    repeat (3) @(posedge clk); #1 rx_a = 1'b1;
    repeat (400) @(posedge clk);
    chk("glitch_no_resp", 32'(rq_a.size()), 32'd0);
    chk("glitch_no_req", 32'(txn_size(0)), 32'(n0));
    chk("glitch_no_fe", 32'(fe_a), 32'(fe0));
    chk("glitch_busy", 32'(busy_a), 32'd0);

    run_cmd(0, 1'b1, 32'h0000_0001, 32'h00FF_00FF, 4, 1, 1'b0);
    run_cmd(0, 1'b0, $urandom, $urandom, 2, -1, 1'b1);
    for (int i = 0; i < 6; i++)
      run_cmd(0, 1'($urandom_range(0, 1)), $urandom, $urandom, $urandom_range(0, 12), -1, 1'b0);

    run_cmd(1, 1'b1, 32'h0000_1234, 32'h0000_00AB, 5, -1, 1'b0);
    for (int i = 0; i < 3; i++)
      run_cmd(1, 1'($urandom_range(0, 1)), $urandom, $urandom, $urandom_range(0, 8), -1, 1'b0);

    ack_dly_a = 1000000;
    send_byte(0, 8'h56, 1'b1);
    for (int k = 0; k < 8; k++) send_byte(0, 8'($urandom), 1'b1);
    c = 0;
    while (bus_req_a !== 1'b1 && c < 500) begin @(posedge clk); c++; end
    chk("req_before_reset", 32'(bus_req_a), 32'd1);
    repeat (3) @(posedge clk);
    #1 reset_L = 1'b0;
    #1;
    chk("reset_bus_req", 32'(bus_req_a), 32'd0);
    chk("reset_tx", 32'(tx_a), 32'd1);
    chk("reset_busy", 32'(busy_a), 32'd0);
    repeat (3) @(posedge clk);
    #1 reset_L = 1'b1;
    repeat (10) @(posedge clk);
    run_cmd(0, 1'b1, $urandom, $urandom, 3, -1, 1'b0);

`ifdef UART_CMD_TIMEOUT_EN
    rq_a.delete(); n0 = txn_size(0);
    send_byte(0, 8'h56, 1'b1);
    send_byte(0, 8'h01, 1'b1);
    repeat (TO + 1) @(posedge clk);
    wait_bytes(0, 1, 1000, "timeout_count");
    if (rq_a.size() > 0) chk("timeout_resp", 32'(rq_a[0]), 32'h15);
    chk("timeout_no_req", 32'(txn_size(0)), 32'(n0));
    chk("timeout_busy", 32'(busy_a), 32'd0);
    repeat (CPB * 2) @(posedge clk);
    run_cmd(0, 1'b1, $urandom, $urandom, 2, -1, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
